// File: rtl/imem_param_if.sv
// Load/fetch bus for the parameterized instruction memory.
// The master drives load words and fetch requests; the slave is the memory.
interface imem_param_if #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned DEPTH  = 32
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [CNT_W-1:0]  load_count;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_inst;
  logic              fetch_err;
  logic [1:0]        mode;

  modport master (
    output load_start, load_valid, load_data, load_last,
    output fetch_req, fetch_addr, fetch_stall,
    input  load_ready, load_done, load_count,
    input  fetch_valid, fetch_inst, fetch_err, mode
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  fetch_req, fetch_addr, fetch_stall,
    output load_ready, load_done, load_count,
    output fetch_valid, fetch_inst, fetch_err, mode
  );
endinterface

// File: rtl/imem_param.sv
// Parameterized instruction memory: burst load port (IDLE/LOAD/RUN) and a
// single-cycle-latency fetch port with stall hold and out-of-range flagging.
module imem_param #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned DEPTH  = 32
) (
  input logic         clk,
  input logic         rst_n,
  imem_param_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] wptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ready_q, done_q, valid_q, err_q;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept_c, last_c, enter_load_c, run_hold_c, oob_c;

  // Next-state and load/fetch qualifiers.
  always_comb begin
    state_nx = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.load_start) state_nx = LOAD;
      LOAD: begin
        accept_c = bus.load_valid;
        last_c   = bus.load_last || (wptr_q == ADDR_W'(DEPTH - 1));
        if (accept_c && last_c) state_nx = RUN;
      end
      RUN:  if (bus.load_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
    enter_load_c = (state_q != LOAD) && (state_nx == LOAD);
    // A reload request in RUN kills any fetch result, stalled or not.
    run_hold_c   = (state_q == RUN) && (state_nx == RUN);
    oob_c        = 32'(bus.fetch_addr) >= DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_nx;
      ready_q <= (state_nx == LOAD);
      done_q  <= accept_c && last_c;

      if (enter_load_c) begin
        wptr_q  <= '0;
        count_q <= '0;
      end else if (accept_c) begin
        wptr_q  <= wptr_q + ADDR_W'(1);
        count_q <= count_q + CNT_W'(1);
      end

      if (!run_hold_c) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else if (!bus.fetch_stall) begin
        valid_q <= bus.fetch_req;
        err_q   <= bus.fetch_req && oob_c;
        if (bus.fetch_req) inst_q <= oob_c ? '0 : mem[bus.fetch_addr];
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_c) mem[wptr_q] <= bus.load_data;
  end

  assign bus.mode        = state_q;
  assign bus.load_ready  = ready_q;
  assign bus.load_done   = done_q;
  assign bus.load_count  = count_q;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_inst  = inst_q;
  assign bus.fetch_err   = err_q;
endmodule
